// File: rtl/fir_audio_filter_param.sv
// Stereo FIR filter with one time-multiplexed MAC per channel, double-buffered
// run-time coefficients, round-half-up, saturation and bypass.
module fir_audio_filter_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int TAPS   = 9,
  parameter int FRAC   = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [2*DATA_W-1:0]        audio_in,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_wdata,
  input  logic                       coef_commit,
  input  logic                       bypass,
  output logic [2*DATA_W-1:0]        audio_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       drop,
  output logic                       sat
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  localparam logic [AW-1:0]            K_LAST   = AW'(TAPS - 1);
  localparam logic [AW-1:0]            K_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]              TAPS_L   = (AW+1)'(TAPS);
  localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [ACC_W-1:0]  HALF_A   = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0]  MAX_A    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  MIN_A    = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [AW-1:0]              k_r;
  logic signed [DATA_W-1:0]   xl_r [TAPS];
  logic signed [DATA_W-1:0]   xr_r [TAPS];
  logic signed [COEF_W-1:0]   shadow_r [TAPS];
  logic signed [COEF_W-1:0]   active_r [TAPS];
  logic signed [ACC_W-1:0]    acc_l_r;
  logic signed [ACC_W-1:0]    acc_r_r;
  logic                       pend_r;
  logic [2*DATA_W-1:0]        audio_out_r;
  logic                       out_valid_r;
  logic                       drop_r;
  logic                       sat_r;

  logic                       idle_s;
  logic                       accept_s;
  logic                       copy_s;
  logic                       wr_ok_s;
  logic signed [PROD_W-1:0]   prod_l_s;
  logic signed [PROD_W-1:0]   prod_r_s;
  logic [DATA_W:0]            res_l_s;
  logic [DATA_W:0]            res_r_s;

  // Round half toward +inf, then clip; MSB of the result flags a clip.
  function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + HALF_A) >>> FRAC;
    if (r > MAX_A) begin
      return {1'b1, MAX_A[DATA_W-1:0]};
    end else if (r < MIN_A) begin
      return {1'b1, MIN_A[DATA_W-1:0]};
    end else begin
      return {1'b0, r[DATA_W-1:0]};
    end
  endfunction

  assign idle_s   = (state_r == IDLE);
  assign accept_s = idle_s && sample_valid;
  // A commit that meets a new sample waits until after that sample.
  assign copy_s   = idle_s && !sample_valid && (coef_commit || pend_r);
  assign wr_ok_s  = coef_we && ({1'b0, coef_addr} < TAPS_L);

  assign prod_l_s = PROD_W'(active_r[k_r]) * PROD_W'(xl_r[k_r]);
  assign prod_r_s = PROD_W'(active_r[k_r]) * PROD_W'(xr_r[k_r]);
  assign res_l_s  = round_sat(acc_l_r);
  assign res_r_s  = round_sat(acc_r_r);

  assign audio_out = audio_out_r;
  assign out_valid = out_valid_r;
  assign busy      = !idle_s;
  assign drop      = drop_r;
  assign sat       = sat_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_valid) begin
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ROUND;
        end else begin
          state_nxt_s = MAC;
        end
      end
      ROUND:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Shadow/active coefficient banks and the pending-commit flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_r[i] <= (i == 0) ? COEF_ONE : {COEF_W{1'b0}};
        active_r[i] <= (i == 0) ? COEF_ONE : {COEF_W{1'b0}};
      end
      pend_r <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (wr_ok_s && (coef_addr == AW'(i))) begin
          shadow_r[i] <= coef_wdata;
        end
        // Forward a same-cycle write so the commit includes it.
        if (copy_s) begin
          active_r[i] <= (wr_ok_s && (coef_addr == AW'(i))) ? coef_wdata : shadow_r[i];
        end
      end
      pend_r <= (pend_r || coef_commit) && !copy_s;
    end
  end

  // Delay lines, accumulators, tap counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        xl_r[i] <= {DATA_W{1'b0}};
        xr_r[i] <= {DATA_W{1'b0}};
      end
      acc_l_r     <= {ACC_W{1'b0}};
      acc_r_r     <= {ACC_W{1'b0}};
      k_r         <= {AW{1'b0}};
      audio_out_r <= {(2*DATA_W){1'b0}};
      out_valid_r <= 1'b0;
      drop_r      <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      sat_r       <= 1'b0;
      drop_r      <= sample_valid && !idle_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              xl_r[i] <= xl_r[i-1];
              xr_r[i] <= xr_r[i-1];
            end
            xl_r[0] <= audio_in[2*DATA_W-1:DATA_W];
            xr_r[0] <= audio_in[DATA_W-1:0];
            acc_l_r <= {ACC_W{1'b0}};
            acc_r_r <= {ACC_W{1'b0}};
            k_r     <= {AW{1'b0}};
          end
        end
        MAC: begin
          acc_l_r <= acc_l_r + ACC_W'(prod_l_s);
          acc_r_r <= acc_r_r + ACC_W'(prod_r_s);
          k_r     <= k_r + K_ONE;
        end
        ROUND: begin
          out_valid_r <= 1'b1;
          if (bypass) begin
            audio_out_r <= {xl_r[0], xr_r[0]};
            sat_r       <= 1'b0;
          end else begin
            audio_out_r <= {res_l_s[DATA_W-1:0], res_r_s[DATA_W-1:0]};
            sat_r       <= res_l_s[DATA_W] || res_r_s[DATA_W];
          end
        end
        default: begin
          k_r <= {AW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_audio_filter_param.sv
// Directed self-checking bench for fir_audio_filter_param (default parameters).
module tb_fir_audio_filter_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] audio_in = 32'h0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = 4'h0;
  logic [17:0] coef_wdata = 18'h0;
  logic        coef_commit = 1'b0;
  logic        bypass = 1'b0;
  logic [31:0] audio_out;
  logic        out_valid;
  logic        busy;
  logic        drop;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_audio_filter_param dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .coef_commit  (coef_commit),
    .bypass       (bypass),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .drop         (drop),
    .sat          (sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    coef_commit = 1'b0;
    bypass = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [17:0] v);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic commit_bank();
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
  endtask

  // One sample in, wait for its output, check latency, data, sat and pulse width.
  // at >= 0 also writes coef[0]=c0 with a commit at that cycle after the strobe.
  task automatic run_cycle(input string tag, input logic [31:0] d, input logic [31:0] exp_d,
                           input logic exp_sat, input int at, input logic [17:0] c0);
    int cyc;
    cyc = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    audio_in = d;
    if (at == 0) begin
      coef_we = 1'b1; coef_addr = 4'h0; coef_wdata = c0; coef_commit = 1'b1;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        sample_valid = 1'b0;
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'h1);
      end
      if (c == at) begin
        coef_we = 1'b1; coef_addr = 4'h0; coef_wdata = c0; coef_commit = 1'b1;
      end
      if (c == at + 1) begin
        coef_we = 1'b0; coef_commit = 1'b0;
      end
      if (out_valid) begin
        cyc = c;
        break;
      end
    end
    check_eq({tag, "_lat"}, cyc, 32'd11);
    check_eq({tag, "_data"}, audio_out, exp_d);
    check_eq({tag, "_sat"}, {31'h0, sat}, {31'h0, exp_sat});
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'h0, out_valid}, 32'h0);
  endtask

  task automatic run_sample(input string tag, input logic [31:0] d, input logic [31:0] exp_d,
                            input logic exp_sat);
    run_cycle(tag, d, exp_d, exp_sat, -5, 18'h0);
  endtask

  initial begin
    int ov_cnt;
    int ov_cyc;
    logic [31:0] ov_data;
    logic [15:0] el;
    logic [15:0] er;

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out", audio_out, 32'h0);
    check_eq("rst_flags", {28'h0, out_valid, busy, drop, sat}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1: identity bank passes the sample through
    run_sample("t1", 32'h1234_FEDC, 32'h1234_FEDC, 1'b0);

    // 2: impulse response with coef[k] = k*4096
    do_reset();
    for (int k = 0; k < 9; k++) wr_coef(4'(k), 18'(k * 4096));
    commit_bank();
    for (int n = 0; n < 9; n++) begin
      el = 16'(2048 * n);
      er = 16'(-2048 * n);
      run_sample("t2", (n == 0) ? 32'h4000_C000 : 32'h0, {el, er}, 1'b0);
    end

    // 3a: rounding half toward +inf with coef[0]=0.5
    do_reset();
    wr_coef(4'd0, 18'd16384);
    commit_bank();
    run_sample("t3a", 32'h0003_FFFD, 32'h0002_FFFF, 1'b0);

    // 3b: saturation with all coefficients 1.0, then bypass suppresses it
    do_reset();
    for (int k = 0; k < 9; k++) wr_coef(4'(k), 18'd32768);
    commit_bank();
    for (int n = 0; n < 9; n++) run_sample("t3b", 32'h7FFF_8000, 32'h7FFF_8000, n >= 1);
    bypass = 1'b1;
    run_sample("t3byp", 32'h0001_0002, 32'h0001_0002, 1'b0);
    bypass = 1'b0;

    // 4: overrun; coef[0]=coef[1]=1.0 so the next output reveals the history
    do_reset();
    wr_coef(4'd1, 18'd32768);
    commit_bank();
    ov_cnt = 0; ov_cyc = 0; ov_data = 32'h0;
    @(negedge clk);
    sample_valid = 1'b1;
    audio_in = 32'h0100_0200;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) sample_valid = 1'b0;
      if (c == 4) begin
        sample_valid = 1'b1;
        audio_in = 32'h0300_0400;
      end
      if (c == 5) begin
        sample_valid = 1'b0;
        check_eq("t4_drop", {31'h0, drop}, 32'h1);
      end
      if (c == 6) check_eq("t4_drop_end", {31'h0, drop}, 32'h0);
      if (out_valid) begin
        ov_cnt++;
        if (ov_cnt == 1) begin
          ov_cyc = c;
          ov_data = audio_out;
        end
      end
    end
    check_eq("t4_ov_cnt", ov_cnt, 32'd1);
    check_eq("t4_ov_cyc", ov_cyc, 32'd11);
    check_eq("t4_data", ov_data, 32'h0100_0200);
    run_sample("t4_next", 32'h0010_0020, 32'h0110_0220, 1'b0);

    // 5: commits during a computation apply only to later samples
    do_reset();
    run_cycle("t5a", 32'h0123_0456, 32'h0123_0456, 1'b0, 0, 18'd0);
    run_sample("t5a_next", 32'h0777_0888, 32'h0, 1'b0);
    run_cycle("t5b", 32'h0222_0333, 32'h0, 1'b0, 3, 18'd32768);
    run_sample("t5b_next", 32'h0444_0555, 32'h0444_0555, 1'b0);

    // 6: reset mid-MAC aborts the computation
    do_reset();
    run_sample("t6_pre", 32'h0ABC_0DEF, 32'h0ABC_0DEF, 1'b0);
    @(negedge clk);
    sample_valid = 1'b1;
    audio_in = 32'h0555_0666;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) sample_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_eq("t6_busy", {31'h0, busy}, 32'h0);
    check_eq("t6_out", audio_out, 32'h0);
    ov_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b1;
      if (out_valid) ov_cnt++;
    end
    check_eq("t6_no_ov", ov_cnt, 32'd0);
    run_sample("t6_post", 32'h0F0F_7070, 32'h0F0F_7070, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
